vga_write_arbiter: RTL

Shares the single VGA framebuffer pixel-write port between drawing clients: the player sprite, the obstacle engine(s) and the score/HUD painter. Each client raises a burst request, waits for a one-hot grant, then streams pixel writes that the arbiter registers onto the shared VGA_x/VGA_y/VGA_color/VGA_write port. Grants are non-preemptive per burst with round-robin fairness. A client-0 urgent input lets the player win the next arbitration while it is red (collision mode), so its sprite lands on top of obstacles. The block sits between all drawing FSMs and the VGA adapter.

---
 rtl/vga_write_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: shares the framebuffer pixel-write port between drawing
// clients using non-preemptive round-robin bursts and a player urgent boost.
// Ports:
//   Clock, Reset                  system clock, sync active-high reset
//   req, urgent                   burst requests, client-0 priority boost
//   wr, x_in, y_in, color_in      per-client pixel streams (packed by client)
//   gnt                           registered one-hot grant
//   VGA_x, VGA_y, VGA_color,
//   VGA_write                     registered shared pixel port
//   busy, drop, timeout           status (drop/timeout sticky until Reset)
module vga_write_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int nX          = 10,
    parameter int nY          = 9,
    parameter int COLOR_DEPTH = 9,
    parameter int MAX_BURST   = 4096
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic [NUM_CLIENTS-1:0]         req,
    input  logic                           urgent,
    input  logic [NUM_CLIENTS-1:0]         wr,
    input  logic [NUM_CLIENTS*nX-1:0]      x_in,
    input  logic [NUM_CLIENTS*nY-1:0]      y_in,
    input  logic [NUM_CLIENTS*COLOR_DEPTH-1:0] color_in,
    output logic [NUM_CLIENTS-1:0]         gnt,
    output logic [nX-1:0]                  VGA_x,
    output logic [nY-1:0]                  VGA_y,
    output logic [COLOR_DEPTH-1:0]         VGA_color,
    output logic                           VGA_write,
    output logic                           busy,
    output logic [NUM_CLIENTS-1:0]         drop,
    output logic                           timeout
);

    localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t                 state, state_nxt;
    logic [IW-1:0]          owner, owner_nxt;
    logic [IW-1:0]          rr_ptr, rr_ptr_nxt;
    logic [IW-1:0]          pick;
    logic                   pick_vld;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [NUM_CLIENTS-1:0] gnt_nxt;
    logic                   at_limit;
    logic                   release_now;
    logic                   we_nxt;
    logic                   to_set;
    logic [nX-1:0]          own_x;
    logic [nY-1:0]          own_y;
    logic [COLOR_DEPTH-1:0] own_c;

    assign own_x = x_in[int'(owner)*nX +: nX];
    assign own_y = y_in[int'(owner)*nY +: nY];
    assign own_c = color_in[int'(owner)*COLOR_DEPTH +: COLOR_DEPTH];

    assign at_limit    = (cnt == CW'(MAX_BURST - 1));
    assign release_now = !req[owner] || at_limit;
    assign busy        = (state != IDLE);

    // Winner search: urgent player first, otherwise the first requester
    // found walking upward (with wrap) from the round-robin pointer.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = '0;
        pick_vld = 1'b0;
        if (req[0] && urgent) begin
            pick_vld = 1'b1;
        end else begin
            for (int k = 0; k < NUM_CLIENTS; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_CLIENTS;
                if (!pick_vld && req[idx]) begin
                    pick     = IW'(idx);
                    pick_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        cnt_nxt    = cnt;
        gnt_nxt    = gnt;
        we_nxt     = 1'b0;
        to_set     = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    owner_nxt = pick;
                    gnt_nxt   = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << pick;
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // The owner's write in its release cycle still goes out.
                we_nxt  = wr[owner];
                cnt_nxt = cnt + CW'(1);
                if (release_now) begin
                    gnt_nxt    = '0;
                    to_set     = at_limit;
                    rr_ptr_nxt = (int'(owner) == NUM_CLIENTS - 1) ?
                                 '0 : owner + IW'(1);
                    state_nxt  = GAP;
                end
            end
            GAP: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            gnt       <= '0;
            VGA_x     <= '0;
            VGA_y     <= '0;
            VGA_color <= '0;
            VGA_write <= 1'b0;
            drop      <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            cnt       <= cnt_nxt;
            gnt       <= gnt_nxt;
            VGA_write <= we_nxt;
            if (we_nxt) begin
                VGA_x     <= own_x;
                VGA_y     <= own_y;
                VGA_color <= own_c;
            end
            // Writes from clients not holding the grant are discarded.
            drop    <= drop | (wr & ~gnt);
            timeout <= timeout | to_set;
        end
    end

endmodule
